smem_bank_scheduler: RTL and testbench
======================================

Name: smem_bank_scheduler

Overview:
Sequencing controller in front of the banked shared-memory array. It accepts one warp-wide load/store, splits it into conflict-free passes, and drives the per-bank SRAM ports pass by pass. Lanes that read the same bank and word are serviced together in one pass (broadcast). It gathers read data per lane and returns a single warp response.

Parameters:
WARP_SIZE, 32, lanes per request
NUM_BANKS, 32, bank count (power of 2); bank = addr[log2(NUM_BANKS)+1:2]
DATA_WIDTH, 32, word width
ADDR_WIDTH, 16, byte address width
WORD_W, ADDR_WIDTH-log2(NUM_BANKS)-2, per-bank word index width; word = addr[ADDR_WIDTH-1:log2(NUM_BANKS)+2]

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  warp request valid
req_ready  out  1  high only in IDLE
req_we  in  1  1=store, 0=load (whole warp)
req_addr  in  WARP_SIZE x ADDR_WIDTH  per-lane byte address
req_wdata  in  WARP_SIZE x DATA_WIDTH  per-lane store data
req_mask  in  WARP_SIZE  active lanes
bank_en  out  NUM_BANKS  per-bank access strobe
bank_we  out  1  write enable, common to all banks
bank_word  out  NUM_BANKS x WORD_W  per-bank word index
bank_wdata  out  NUM_BANKS x DATA_WIDTH  per-bank write data
bank_rdata  in  NUM_BANKS x DATA_WIDTH  read data, valid 1 cycle after bank_en
resp_valid  out  1  one-cycle completion pulse; no backpressure
resp_rdata  out  WARP_SIZE x DATA_WIDTH  per-lane load data
resp_lanes  out  WARP_SIZE  latched req_mask
conflict_detected  out  1  current or last request needed more than one pass
conflict_lanes  out  WARP_SIZE  lanes not serviced in pass 1
pass_count  out  6  passes used by current or last request

Behaviour:
- Reset (async): state=IDLE, req_ready=1. All other outputs are 0, including all bank_* outputs, resp_*, conflict_*, and pass_count. Internal pending, address and data latches are cleared.
- A request is accepted on the clock edge where req_valid && req_ready. At that edge the block latches we, addr, wdata and mask, sets pending=mask, and clears resp_rdata, conflict_lanes and pass_count. It enters ISSUE; if mask==0 it enters RESP instead.
- Pass selection (combinational on pending), per bank b:
  - Leader = lowest-index pending lane with bank==b.
  - Serviced set = all pending lanes with bank==b and word==leader word.
  - bank_en[b]=1 if a leader exists. bank_word[b] = leader word.
- Store with several lanes in one serviced set (same address): the highest-index lane's wdata is written.
- ISSUE: drive the bank ports for one pass and increment pass_count. Clear the serviced lanes from pending.
  - On the first ISSUE of a request, latch conflict_lanes = pending & ~serviced, and conflict_detected = |that.
  - Load: next state CAPTURE.
  - Store: next state ISSUE if pending!=0 after clearing, else RESP.
- CAPTURE: all bank_en=0. For each lane serviced in the previous pass, resp_rdata[lane] <= bank_rdata[bank(lane)]. Next state ISSUE if pending!=0, else RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - resp_rdata holds its values until the next accept.
  - Unmasked lanes read 0.
- bank_* outputs are driven only in ISSUE; bank_en=0 in all other states.
- Latency, with acceptance at edge T and P passes:
  - Load: resp_valid is high in cycle T+2P+1.
  - Store: resp_valid is high in cycle T+P+1.
  - mask==0: resp_valid is high in cycle T+1 with pass_count=0.
- P ranges from 1 to WARP_SIZE. Each pass services at least one lane, so the request always terminates.
- conflict_*, pass_count and resp_lanes hold until the next accept.
- Reset mid-operation: abort immediately. No resp_valid is generated, and no further bank_en follows.
- req_valid while busy is ignored (req_ready=0). The requester must hold it.

Test Plan:
- Strided load, addr[i]=4*i, full mask, array preloaded with A0000000+i -> pass_count=1, conflict_detected=0, resp_valid at T+3, resp_rdata[i]=A0000000+i.
- Same-bank store, addr[i]=128*i, wdata B0000000+i -> 32 ISSUE cycles each with only bank_en[0]=1 and bank_word=i; conflict_lanes=FFFFFFFE; resp at T+33. Readback load -> resp at T+65 with correct data.
- Broadcast load, all lanes addr=0x0200 holding C0DECAFE -> one pass with only bank_en[0] and bank_word=4; conflict_detected=0; all lanes return C0DECAFE.
- Mixed: lanes 0-3 addr=128*i, lanes 4-7 addr=4+128*(i-4), lanes 8-31 addr=4*i -> pass_count=4, conflict_lanes=000000EE; mask 55555555 store -> only even lanes written and resp_lanes=55555555.
- Lanes 0 and 5 store to 0x0400 with 11111111 and 55555555 -> one pass, bank_wdata=55555555; mask=0 -> resp_valid at T+1, pass_count=0, no bank_en.
- Assert rst_n=0 during pass 3 of the same-bank load -> outputs zero immediately, no resp_valid, req_ready=1 after release, next request completes normally.

Source files
------------

// File: rtl/smem_bank_scheduler.sv
// Banked shared-memory sequencer: splits one warp access into conflict-free passes,
// broadcasting same-word reads, and gathers load data into a single warp response.
module smem_bank_scheduler #(
   parameter int unsigned WARP_SIZE  = 32,
   parameter int unsigned NUM_BANKS  = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          req_valid,
   output logic                                          req_ready,
   input  logic                                          req_we,
   input  logic [WARP_SIZE*ADDR_WIDTH-1:0]               req_addr,
   input  logic [WARP_SIZE*DATA_WIDTH-1:0]               req_wdata,
   input  logic [WARP_SIZE-1:0]                          req_mask,
   output logic [NUM_BANKS-1:0]                          bank_en,
   output logic                                          bank_we,
   output logic [NUM_BANKS*(ADDR_WIDTH-$clog2(NUM_BANKS)-2)-1:0] bank_word,
   output logic [NUM_BANKS*DATA_WIDTH-1:0]               bank_wdata,
   input  logic [NUM_BANKS*DATA_WIDTH-1:0]               bank_rdata,
   output logic                                          resp_valid,
   output logic [WARP_SIZE*DATA_WIDTH-1:0]               resp_rdata,
   output logic [WARP_SIZE-1:0]                          resp_lanes,
   output logic                                          conflict_detected,
   output logic [WARP_SIZE-1:0]                          conflict_lanes,
   output logic [5:0]                                    pass_count
);

   localparam int unsigned BANK_W = $clog2(NUM_BANKS);
   localparam int unsigned WORD_W = ADDR_WIDTH - BANK_W - 2;

   typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

   state_e                          state_q;
   logic                            we_q;
   logic [WARP_SIZE*ADDR_WIDTH-1:0] addr_q;
   logic [WARP_SIZE*DATA_WIDTH-1:0] wdata_q;
   logic [WARP_SIZE-1:0]            pending_q;
   logic [WARP_SIZE-1:0]            serviced_q;
   logic [WARP_SIZE*DATA_WIDTH-1:0] resp_rdata_q;
   logic [WARP_SIZE-1:0]            resp_lanes_q;
   logic                            conflict_q;
   logic [WARP_SIZE-1:0]            conflict_lanes_q;
   logic [5:0]                      pass_q;

   logic [BANK_W-1:0]     lane_bank [WARP_SIZE];
   logic [WORD_W-1:0]     lane_word [WARP_SIZE];
   logic [NUM_BANKS-1:0]  lead_found;
   logic [WORD_W-1:0]     lead_word [NUM_BANKS];
   logic [DATA_WIDTH-1:0] sel_wdata [NUM_BANKS];
   logic [WARP_SIZE-1:0]  serviced;
   logic [WARP_SIZE-1:0]  pending_nxt;

   // Pass selection: the lowest pending lane claims each bank; ascending scan lets the
   // highest serviced lane's store data win on same-address collisions.
   always_comb begin
      lead_found = '0;
      serviced   = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         lead_word[b] = '0;
         sel_wdata[b] = '0;
      end
      for (int l = 0; l < WARP_SIZE; l++) begin
         lane_bank[l] = addr_q[l*ADDR_WIDTH+2 +: BANK_W];
         lane_word[l] = addr_q[l*ADDR_WIDTH+BANK_W+2 +: WORD_W];
      end
      for (int l = 0; l < WARP_SIZE; l++) begin
         if (pending_q[l] && !lead_found[lane_bank[l]]) begin
            lead_found[lane_bank[l]] = 1'b1;
            lead_word[lane_bank[l]]  = lane_word[l];
         end
      end
      for (int l = 0; l < WARP_SIZE; l++) begin
         if (pending_q[l] && lane_word[l] == lead_word[lane_bank[l]]) begin
            serviced[l]              = 1'b1;
            sel_wdata[lane_bank[l]]  = wdata_q[l*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      pending_nxt = pending_q & ~serviced;
   end

   always_comb begin
      bank_en    = '0;
      bank_word  = '0;
      bank_wdata = '0;
      if (state_q == StIssue) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            bank_en[b]                      = lead_found[b];
            bank_word[b*WORD_W +: WORD_W]   = lead_word[b];
            if (we_q) bank_wdata[b*DATA_WIDTH +: DATA_WIDTH] = sel_wdata[b];
         end
      end
   end

   assign bank_we           = (state_q == StIssue) && we_q;
   assign req_ready         = (state_q == StIdle);
   assign resp_valid        = (state_q == StResp);
   assign resp_rdata        = resp_rdata_q;
   assign resp_lanes        = resp_lanes_q;
   assign conflict_detected = conflict_q;
   assign conflict_lanes    = conflict_lanes_q;
   assign pass_count        = pass_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= StIdle;
         we_q             <= 1'b0;
         addr_q           <= '0;
         wdata_q          <= '0;
         pending_q        <= '0;
         serviced_q       <= '0;
         resp_rdata_q     <= '0;
         resp_lanes_q     <= '0;
         conflict_q       <= 1'b0;
         conflict_lanes_q <= '0;
         pass_q           <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  we_q             <= req_we;
                  addr_q           <= req_addr;
                  wdata_q          <= req_wdata;
                  pending_q        <= req_mask;
                  serviced_q       <= '0;
                  resp_rdata_q     <= '0;
                  resp_lanes_q     <= req_mask;
                  conflict_q       <= 1'b0;
                  conflict_lanes_q <= '0;
                  pass_q           <= '0;
                  state_q          <= (req_mask == '0) ? StResp : StIssue;
               end
            end
            StIssue: begin
               pending_q  <= pending_nxt;
               serviced_q <= serviced;
               pass_q     <= pass_q + 6'd1;
               if (pass_q == '0) begin
                  conflict_lanes_q <= pending_nxt;
                  conflict_q       <= |pending_nxt;
               end
               if (!we_q)                   state_q <= StCapture;
               else if (pending_nxt != '0)  state_q <= StIssue;
               else                         state_q <= StResp;
            end
            StCapture: begin
               for (int l = 0; l < WARP_SIZE; l++) begin
                  if (serviced_q[l]) begin
                     resp_rdata_q[l*DATA_WIDTH +: DATA_WIDTH] <=
                        bank_rdata[int'(lane_bank[l])*DATA_WIDTH +: DATA_WIDTH];
                  end
               end
               state_q <= (pending_q != '0) ? StIssue : StResp;
            end
            StResp: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_smem_bank_scheduler.sv
// Directed bench: SRAM array model, expected responses queued at issue, checked by a monitor.
module tb_smem_bank_scheduler;

   localparam int WS = 32;
   localparam int NB = 32;
   localparam int DW = 32;
   localparam int AW = 16;
   localparam int WW = 9;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_valid, req_ready, req_we;
   logic [WS*AW-1:0] req_addr;
   logic [WS*DW-1:0] req_wdata;
   logic [WS-1:0]    req_mask;
   logic [NB-1:0]    bank_en;
   logic             bank_we;
   logic [NB*WW-1:0] bank_word;
   logic [NB*DW-1:0] bank_wdata, bank_rdata, rdata_r;
   logic             resp_valid;
   logic [WS*DW-1:0] resp_rdata;
   logic [WS-1:0]    resp_lanes, conflict_lanes;
   logic             conflict_detected;
   logic [5:0]       pass_count;

   smem_bank_scheduler dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
      .bank_en(bank_en), .bank_we(bank_we), .bank_word(bank_word),
      .bank_wdata(bank_wdata), .bank_rdata(bank_rdata), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_lanes(resp_lanes),
      .conflict_detected(conflict_detected), .conflict_lanes(conflict_lanes),
      .pass_count(pass_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WS-1:0]    lanes;
      logic [WS*DW-1:0] rdata;
      logic [5:0]       passes;
      logic             cdet;
      logic [WS-1:0]    clanes;
      int               lat;
      int               acc;
   } exp_t;

   typedef struct {
      logic [NB-1:0] en;
      logic          we;
      logic [WW-1:0] word0;
      logic [DW-1:0] wdata0;
   } log_t;

   exp_t             exp_q[$];
   log_t             blog[$];
   exp_t             mon_e;
   logic [31:0]      mem  [16384];
   logic [31:0]      gold [16384];
   logic [WS*AW-1:0] addr_v;
   logic [WS*DW-1:0] wdata_v;
   int               cyc = 0;
   int               n_checks = 0;
   int               n_pass = 0;
   int               acc_c;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   function automatic logic [31:0] init_val(input int k);
      if (k < 32)    return 32'hA000_0000 + k;
      if (k == 128)  return 32'hC0DE_CAFE;
      return 32'hD000_0000 + k;
   endfunction

   always @(posedge clk) cyc++;

   // SRAM array: one-cycle read latency per bank
   always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (bank_en[b]) begin
            if (bank_we) mem[int'(bank_word[b*WW +: WW])*NB + b] = bank_wdata[b*DW +: DW];
            else rdata_r[b*DW +: DW] <= mem[int'(bank_word[b*WW +: WW])*NB + b];
         end
      end
   end
   assign bank_rdata = rdata_r;

   always @(negedge clk) begin
      if (|bank_en) blog.push_back('{en: bank_en, we: bank_we, word0: bank_word[WW-1:0],
                                      wdata0: bank_wdata[DW-1:0]});
      if (resp_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_resp: resp_valid=1, expected 0");
         end else begin
            mon_e = exp_q.pop_front();
            chk("resp_lanes", resp_lanes, mon_e.lanes);
            chk("pass_count", pass_count, mon_e.passes);
            chk("conflict_detected", conflict_detected, mon_e.cdet);
            chk("conflict_lanes", conflict_lanes, mon_e.clanes);
            chk("latency", cyc - mon_e.acc, mon_e.lat);
            for (int l = 0; l < WS; l++)
               chk($sformatf("resp_rdata[%0d]", l), resp_rdata[l*DW +: DW],
                   mon_e.rdata[l*DW +: DW]);
         end
      end
   end

   task automatic run(input logic we, input logic [WS-1:0] mask, input int passes,
                      input logic cdet, input logic [WS-1:0] clanes);
      exp_t e;
      int   k;
      @(negedge clk);
      k = 0;
      while (!req_ready && k < 100) begin @(negedge clk); k++; end
      chk("req_ready_before_req", req_ready, 1);
      blog.delete();
      req_we = we; req_addr = addr_v; req_wdata = wdata_v; req_mask = mask; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      e.lanes = mask; e.passes = 6'(passes); e.cdet = cdet; e.clanes = clanes;
      e.rdata = '0;
      e.lat = (mask == '0) ? 0 : (we ? passes : 2 * passes);
      e.acc = cyc;
      for (int l = 0; l < WS; l++) begin
         if (mask[l]) begin
            if (we) gold[int'(addr_v[l*AW+2 +: 14])] = wdata_v[l*DW +: DW];
            else e.rdata[l*DW +: DW] = gold[int'(addr_v[l*AW+2 +: 14])];
         end
      end
      exp_q.push_back(e);
      k = 0;
      while (exp_q.size() != 0 && k < 300) begin @(negedge clk); k++; end
      chk("resp_timeout_pending", exp_q.size(), 0);
   endtask

   task automatic set_lane(input int l, input logic [15:0] a, input logic [31:0] d);
      addr_v[l*AW +: AW]  = a;
      wdata_v[l*DW +: DW] = d;
   endtask

   initial begin
      for (int k = 0; k < 16384; k++) begin mem[k] = init_val(k); gold[k] = init_val(k); end
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      req_mask = '0; addr_v = '0; wdata_v = '0;
      #2;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_bank_en", bank_en, 0);
      chk("rst_bank_we", bank_we, 0);
      chk("rst_bank_word", |bank_word, 0);
      chk("rst_bank_wdata", |bank_wdata, 0);
      chk("rst_resp_rdata", |resp_rdata, 0);
      chk("rst_resp_lanes", resp_lanes, 0);
      chk("rst_conflict", {conflict_detected, conflict_lanes}, 0);
      chk("rst_pass_count", pass_count, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int l = 0; l < WS; l++) set_lane(l, 16'(4 * l), 32'h0);
      run(1'b0, '1, 1, 1'b0, '0);
      chk("strided_log_size", blog.size(), 1);
      if (blog.size() > 0) chk("strided_en", blog[0].en, 32'hFFFF_FFFF);

      for (int l = 0; l < WS; l++) set_lane(l, 16'h0200, 32'h0);
      run(1'b0, '1, 1, 1'b0, '0);
      chk("bcast_log_size", blog.size(), 1);
      if (blog.size() > 0) begin
         chk("bcast_en", blog[0].en, 32'h1);
         chk("bcast_word", blog[0].word0, 4);
      end

      for (int l = 0; l < WS; l++) set_lane(l, 16'(128 * l), 32'hB000_0000 + l);
      run(1'b1, '1, 32, 1'b1, 32'hFFFF_FFFE);
      chk("samebank_log_size", blog.size(), 32);
      for (int i = 0; i < blog.size() && i < 32; i++) begin
         chk($sformatf("samebank_en[%0d]", i), blog[i].en, 32'h1);
         chk($sformatf("samebank_we[%0d]", i), blog[i].we, 1);
         chk($sformatf("samebank_word[%0d]", i), blog[i].word0, i);
         chk($sformatf("samebank_wdata[%0d]", i), blog[i].wdata0, 32'hB000_0000 + i);
      end
      run(1'b0, '1, 32, 1'b1, 32'hFFFF_FFFE);

      for (int l = 0; l < WS; l++) begin
         if (l < 4)      set_lane(l, 16'(128 * l), 32'hE000_0000 + l);
         else if (l < 8) set_lane(l, 16'(4 + 128 * (l - 4)), 32'hE000_0000 + l);
         else            set_lane(l, 16'(4 * l), 32'hE000_0000 + l);
      end
      run(1'b0, '1, 4, 1'b1, 32'h0000_00EE);
      run(1'b1, 32'h5555_5555, 2, 1'b1, 32'h0000_0044);
      run(1'b0, '1, 4, 1'b1, 32'h0000_00EE);

      for (int l = 0; l < WS; l++) set_lane(l, 16'h0400, 32'h0);
      set_lane(0, 16'h0400, 32'h1111_1111);
      set_lane(5, 16'h0400, 32'h5555_5555);
      run(1'b1, 32'h0000_0021, 1, 1'b0, '0);
      chk("dual_log_size", blog.size(), 1);
      if (blog.size() > 0) begin
         chk("dual_en", blog[0].en, 32'h1);
         chk("dual_word", blog[0].word0, 8);
         chk("dual_wdata", blog[0].wdata0, 32'h5555_5555);
      end
      run(1'b0, 32'h0000_0021, 1, 1'b0, '0);

      run(1'b0, '0, 0, 1'b0, '0);
      chk("mask0_no_bank_en", blog.size(), 0);

      // Abort a conflicting load during its third pass
      for (int l = 0; l < WS; l++) set_lane(l, 16'(128 * l), 32'h0);
      @(negedge clk);
      req_we = 1'b0; req_addr = addr_v; req_wdata = wdata_v; req_mask = '1; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      acc_c = cyc;
      for (int k = 0; k < 20 && cyc < acc_c + 4; k++) @(negedge clk);
      chk("abort_pass3_en", bank_en, 32'h1);
      chk("abort_pass3_word", bank_word[WW-1:0], 2);
      rst_n = 1'b0;
      #1;
      chk("abort_bank_en", bank_en, 0);
      chk("abort_resp_valid", resp_valid, 0);
      chk("abort_pass_count", pass_count, 0);
      chk("abort_conflict", {conflict_detected, conflict_lanes}, 0);
      chk("abort_resp_rdata", |resp_rdata, 0);
      blog.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_no_bank_en", blog.size(), 0);
      chk("abort_req_ready", req_ready, 1);

      for (int l = 0; l < WS; l++) set_lane(l, 16'(4 * l), 32'h0);
      run(1'b0, '1, 1, 1'b0, '0);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
